// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC controller: FSM state encoding
// and the arctangent table in Q1.31 (0x80000000 = 180 degrees).
package cordic_pkg;

  localparam int unsigned LUT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Entry k = round(atan(2^-k) / pi * 2^31).
  function automatic logic [31:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 32'h2000_0000;
      4'd1:    atan_lut = 32'h12E4_051D;
      4'd2:    atan_lut = 32'h09FB_385B;
      4'd3:    atan_lut = 32'h0511_11D4;
      4'd4:    atan_lut = 32'h028B_0D43;
      4'd5:    atan_lut = 32'h0145_D7E1;
      4'd6:    atan_lut = 32'h00A2_F61E;
      4'd7:    atan_lut = 32'h0051_7C55;
      4'd8:    atan_lut = 32'h0028_BE53;
      4'd9:    atan_lut = 32'h0014_5F2F;
      4'd10:   atan_lut = 32'h000A_2F98;
      4'd11:   atan_lut = 32'h0005_17CC;
      4'd12:   atan_lut = 32'h0002_8BE6;
      4'd13:   atan_lut = 32'h0001_45F3;
      4'd14:   atan_lut = 32'h0000_A2FA;
      default: atan_lut = 32'h0000_517D;
    endcase
  endfunction

endpackage

// File: rtl/cordic.sv
// Single combinational CORDIC micro-rotation. Circular mode (i_mode = 1)
// rotates x/y; linear mode holds x and only accumulates into y.
module cordic #(
  parameter int p_WIDTH = 32
) (
  input  logic               i_mode,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  input  logic               i_d,
  input  logic [4:0]         i_shift_amnt,
  input  logic [p_WIDTH-1:0] i_lut,
  output logic [p_WIDTH-1:0] o_xnext,
  output logic [p_WIDTH-1:0] o_ynext,
  output logic [p_WIDTH-1:0] o_znext,
  output logic               o_dnext
);

  logic signed [p_WIDTH-1:0] x_sh;
  logic signed [p_WIDTH-1:0] y_sh;

  assign x_sh = $signed(i_x) >>> i_shift_amnt;
  assign y_sh = $signed(i_y) >>> i_shift_amnt;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_xnext = i_x;
    o_ynext = i_y;
    o_znext = i_z;
    if (i_d) begin
      o_xnext = i_x - y_sh;
      o_ynext = i_y + x_sh;
      o_znext = i_z - i_lut;
    end else begin
      o_xnext = i_x + y_sh;
      o_ynext = i_y - x_sh;
      o_znext = i_z + i_lut;
    end
    if (!i_mode) o_xnext = i_x;
  end

  // Next direction follows the sign of the residual angle.
  assign o_dnext = ~o_znext[p_WIDTH-1];

endmodule

// File: rtl/cordic_controller.sv
// Iterative CORDIC controller: accepts one operand set, runs p_ITER
// micro-rotations through a shared stage, then holds the result until taken.
module cordic_controller
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_mode,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z,
  output logic               o_busy
);

  localparam logic [4:0] LAST_CNT = 5'(p_ITER - 1);
  localparam int unsigned LUT_AW  = $clog2(LUT_DEPTH);

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic [p_WIDTH-1:0] x_q, y_q, z_q;
  logic               d_q, mode_q;
  logic               ready_q, valid_q, busy_q;

  logic [p_WIDTH-1:0] x_d, y_d, z_d;
  logic               d_d;
  logic [31:0]        lut32;
  logic [p_WIDTH-1:0] lut_w;

  assign lut32 = atan_lut(cnt_q[LUT_AW-1:0]);

  // Table is Q1.31; align its binary point to the datapath width.
  generate
    if (p_WIDTH == 32) begin : g_lut_eq
      assign lut_w = lut32;
    end else if (p_WIDTH > 32) begin : g_lut_wide
      assign lut_w = {lut32, {(p_WIDTH-32){1'b0}}};
    end else begin : g_lut_narrow
      assign lut_w = lut32[31 -: p_WIDTH];
    end
  endgenerate

  cordic #(.p_WIDTH(p_WIDTH)) u_stage (
    .i_mode       (mode_q),
    .i_x          (x_q),
    .i_y          (y_q),
    .i_z          (z_q),
    .i_d          (d_q),
    .i_shift_amnt (cnt_q),
    .i_lut        (lut_w),
    .o_xnext      (x_d),
    .o_ynext      (y_d),
    .o_znext      (z_d),
    .o_dnext      (d_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      d_q     <= 1'b1;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (i_valid && ready_q) begin
            x_q     <= i_x;
            y_q     <= i_y;
            z_q     <= i_z;
            mode_q  <= i_mode;
            d_q     <= ~i_z[p_WIDTH-1];
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          d_q <= d_d;
          // Counter parks on the last index so no out-of-range shift reaches the stage.
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_z     = z_q;

endmodule
